// File: rtl/memory_request_arbiter_pkg.sv
// Shared types and defaults for the memory request arbiter and its picker.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package memory_request_arbiter_pkg;

   localparam int PHY_ADDR_WIDTH             = 32;
   localparam int MEMORY_ENTRY_BIT_NUM       = 64;
   localparam int MEM_ACCESS_SERIAL_BIT_SIZE = 3;

   localparam int MEM_ARB_MAX_OUTSTANDING = 8;
   localparam int MEM_ARB_STARVE_LIMIT    = 16;

   // Requester indices double as round-robin slot numbers.
   typedef enum logic [1:0] {
      MEM_ARB_IC  = 2'd0,
      MEM_ARB_DCR = 2'd1,
      MEM_ARB_DCW = 2'd2
   } MemArbRequester;

   // Owner of an outstanding read (writes never occupy the table).
   typedef enum logic {
      MEM_ARB_OWNER_IC = 1'b0,
      MEM_ARB_OWNER_DC = 1'b1
   } mem_arb_owner_t;

   typedef struct packed {
      logic           valid;
      mem_arb_owner_t owner;
   } mem_arb_owner_entry_t;

   // (base + step) mod 3 over the three requester slots.
   function automatic logic [1:0] mem_arb_rotate(input logic [1:0] base, input logic [1:0] step);
      logic [2:0] sum;
      sum = {1'b0, base} + {1'b0, step};
      if (sum >= 3'd3) begin
         sum = sum - 3'd3;
      end
      return sum[1:0];
   endfunction

endpackage

// File: rtl/mem_arb_round_robin.sv
// 3-way rotating-priority picker; an override slot, when valid, wins outright.
// Latency: grant is combinational from eligible; the pointer updates at the next edge.
// Backpressure: none; only eligible slots can be granted, pointer holds when nothing is granted.
module mem_arb_round_robin
   import memory_request_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] eligible,
   input  logic       override_vld,
   input  logic [1:0] override_idx,
   output logic       grant_vld,
   output logic [1:0] grant_idx
);

   logic [1:0] ptr_q;
   logic [1:0] ptr_d;
   logic [1:0] cand;

   // Pick the first eligible slot starting at the pointer, unless overridden.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = 2'd0;
      cand      = ptr_q;
      if (override_vld) begin
         grant_vld = 1'b1;
         grant_idx = override_idx;
      end else begin
         // Walk from the farthest slot back so the nearest eligible one is kept.
         for (int k = 2; k >= 0; k--) begin
            cand = mem_arb_rotate(ptr_q, 2'(k));
            if (eligible[cand]) begin
               grant_vld = 1'b1;
               grant_idx = cand;
            end
         end
      end
   end

   // Pointer moves just past the winner; holds when nobody is granted.
   always_comb begin
      ptr_d = ptr_q;
      if (grant_vld) begin
         ptr_d = mem_arb_rotate(grant_idx, 2'd1);
      end
   end

   // Pointer register.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= 2'd0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/memory_request_arbiter.sv
// Arbitrates ICache fill, DCache fill and DCache writeback onto one memory port and routes read returns by serial.
// Latency: ack is combinational in the accept cycle; the memory port shows the request one cycle later.
// Backpressure: reads stall on memAccessReadBusy or a full owner table, writes on memAccessWriteBusy.
// Optional: RSD_MEM_ARB_STARVATION_GUARD_EN adds per-requester starvation counters that override round-robin.
module memory_request_arbiter
   import memory_request_arbiter_pkg::*;
#(
   parameter int MAX_OUTSTANDING = MEM_ARB_MAX_OUTSTANDING,
   parameter int STARVE_LIMIT    = MEM_ARB_STARVE_LIMIT
)(
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  icReq,
   input  logic [PHY_ADDR_WIDTH-1:0]             icAddr,
   output logic                                  icAck,
   input  logic                                  dcReadReq,
   input  logic [PHY_ADDR_WIDTH-1:0]             dcReadAddr,
   output logic                                  dcReadAck,
   input  logic                                  dcWriteReq,
   input  logic [PHY_ADDR_WIDTH-1:0]             dcWriteAddr,
   input  logic [MEMORY_ENTRY_BIT_NUM-1:0]       dcWriteData,
   output logic                                  dcWriteAck,
   output logic                                  memAccessRE,
   output logic                                  memAccessWE,
   output logic [PHY_ADDR_WIDTH-1:0]             memAccessAddr,
   output logic [MEMORY_ENTRY_BIT_NUM-1:0]       memAccessWriteData,
   input  logic                                  memAccessReadBusy,
   input  logic                                  memAccessWriteBusy,
   input  logic [MEM_ACCESS_SERIAL_BIT_SIZE-1:0] nextMemReadSerial,
   input  logic                                  memReadDataReady,
   input  logic [MEM_ACCESS_SERIAL_BIT_SIZE-1:0] memReadSerial,
   input  logic [MEMORY_ENTRY_BIT_NUM-1:0]       memReadData,
   output logic                                  icRespValid,
   output logic                                  dcRespValid,
   output logic [MEMORY_ENTRY_BIT_NUM-1:0]       respData,
   output logic                                  unknownSerialError
);

   localparam int SERIALS = 1 << MEM_ACCESS_SERIAL_BIT_SIZE;
   localparam int CNT_W   = MEM_ACCESS_SERIAL_BIT_SIZE + 1;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

   mem_arb_owner_entry_t owner_q [SERIALS];
   mem_arb_owner_entry_t owner_d [SERIALS];
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 err_q, err_d;
   logic                 re_q, re_d, we_q, we_d;
   logic [PHY_ADDR_WIDTH-1:0]       addr_q, addr_d;
   logic [MEMORY_ENTRY_BIT_NUM-1:0] wdata_q, wdata_d;

   logic       read_ok;
   logic       write_ok;
   logic [2:0] eligible;
   logic       override_vld;
   logic [1:0] override_idx;
   logic       grant_vld;
   logic [1:0] grant_idx;
   logic       accept_rd;
   logic       accept_wr;
   mem_arb_owner_entry_t ret_entry;
   logic       ret_hit;
   logic       ret_miss;

   // Eligibility uses the count before any same-cycle return; nothing is eligible in reset.
   always_comb begin
      read_ok  = !memAccessReadBusy && (count_q < MAX_CNT);
      write_ok = !memAccessWriteBusy;
      eligible = 3'b000;
      if (!rst) begin
         eligible = {dcWriteReq && write_ok, dcReadReq && read_ok, icReq && read_ok};
      end
   end

`ifdef RSD_MEM_ARB_STARVATION_GUARD_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   logic [SW-1:0] starve_q [3];
   logic [SW-1:0] starve_d [3];
   logic [2:0]    reqs;
   logic [2:0]    acks;

   assign reqs = {dcWriteReq, dcReadReq, icReq};
   assign acks = {dcWriteAck, dcReadAck, icAck};

   // A starved eligible requester wins; lowest index among several.
   always_comb begin
      override_vld = 1'b0;
      override_idx = 2'd0;
      for (int i = 2; i >= 0; i--) begin
         if (eligible[i] && (starve_q[i] >= STARVE_MAX)) begin
            override_vld = 1'b1;
            override_idx = 2'(i);
         end
      end
   end

   // Count waiting cycles (saturating at the limit), clear on ack.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         starve_d[i] = starve_q[i];
         if (acks[i]) begin
            starve_d[i] = '0;
         end else if (reqs[i] && (starve_q[i] < STARVE_MAX)) begin
            starve_d[i] = starve_q[i] + SW'(1);
         end
      end
   end

   // Starvation counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            starve_q[i] <= '0;
         end
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   assign override_vld = 1'b0;
   assign override_idx = 2'd0;
`endif

   mem_arb_round_robin u_rr (
      .clk          (clk),
      .rst          (rst),
      .eligible     (eligible),
      .override_vld (override_vld),
      .override_idx (override_idx),
      .grant_vld    (grant_vld),
      .grant_idx    (grant_idx)
   );

   assign icAck      = grant_vld && (grant_idx == MEM_ARB_IC);
   assign dcReadAck  = grant_vld && (grant_idx == MEM_ARB_DCR);
   assign dcWriteAck = grant_vld && (grant_idx == MEM_ARB_DCW);
   assign accept_rd  = icAck || dcReadAck;
   assign accept_wr  = dcWriteAck;

   // Route a read return to its owner in the same cycle; unknown serials only flag an error.
   always_comb begin
      ret_entry   = owner_q[memReadSerial];
      ret_hit     = !rst && memReadDataReady && ret_entry.valid;
      ret_miss    = !rst && memReadDataReady && !ret_entry.valid;
      icRespValid = ret_hit && (ret_entry.owner == MEM_ARB_OWNER_IC);
      dcRespValid = ret_hit && (ret_entry.owner == MEM_ARB_OWNER_DC);
      respData    = ret_hit ? memReadData : '0;
   end

   // Owner table, outstanding count and sticky error; a return frees its slot before a same-cycle accept reuses it.
   always_comb begin
      owner_d = owner_q;
      count_d = count_q;
      err_d   = err_q;
      if (ret_hit) begin
         owner_d[memReadSerial] = '0;
      end
      if (accept_rd) begin
         if (owner_q[nextMemReadSerial].valid &&
             !(ret_hit && (memReadSerial == nextMemReadSerial))) begin
            err_d = 1'b1;
         end
         owner_d[nextMemReadSerial] = '{valid: 1'b1,
                                        owner: (icAck ? MEM_ARB_OWNER_IC : MEM_ARB_OWNER_DC)};
      end
      if (ret_miss) begin
         err_d = 1'b1;
      end
      case ({accept_rd, ret_hit})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Memory port contents for the cycle after acceptance; zero when idle.
   always_comb begin
      re_d    = accept_rd;
      we_d    = accept_wr;
      addr_d  = '0;
      wdata_d = '0;
      if (icAck) begin
         addr_d = icAddr;
      end else if (dcReadAck) begin
         addr_d = dcReadAddr;
      end else if (dcWriteAck) begin
         addr_d  = dcWriteAddr;
         wdata_d = dcWriteData;
      end
   end

   // State and memory-port registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SERIALS; i++) begin
            owner_q[i] <= '0;
         end
         count_q <= '0;
         err_q   <= 1'b0;
         re_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         owner_q <= owner_d;
         count_q <= count_d;
         err_q   <= err_d;
         re_q    <= re_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign memAccessRE        = re_q;
   assign memAccessWE        = we_q;
   assign memAccessAddr      = addr_q;
   assign memAccessWriteData = wdata_q;
   assign unknownSerialError = err_q;

endmodule

// File: tb/tb_memory_request_arbiter.sv
// Directed and randomized checks of memory_request_arbiter against a queue/array reference model.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_memory_request_arbiter;
   import memory_request_arbiter_pkg::*;

   localparam int MAXO = MEM_ARB_MAX_OUTSTANDING;
   localparam int SLIM = MEM_ARB_STARVE_LIMIT;

   logic        clk = 1'b0;
   logic        rst;
   logic        icReq, dcReadReq, dcWriteReq;
   logic [31:0] icAddr, dcReadAddr, dcWriteAddr;
   logic [63:0] dcWriteData;
   logic        icAck, dcReadAck, dcWriteAck;
   logic        memAccessRE, memAccessWE;
   logic [31:0] memAccessAddr;
   logic [63:0] memAccessWriteData;
   logic        memAccessReadBusy, memAccessWriteBusy;
   logic [2:0]  nextMemReadSerial;
   logic        memReadDataReady;
   logic [2:0]  memReadSerial;
   logic [63:0] memReadData;
   logic        icRespValid, dcRespValid;
   logic [63:0] respData;
   logic        unknownSerialError;

   memory_request_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SLIM)) dut (
      .clk(clk), .rst(rst),
      .icReq(icReq), .icAddr(icAddr), .icAck(icAck),
      .dcReadReq(dcReadReq), .dcReadAddr(dcReadAddr), .dcReadAck(dcReadAck),
      .dcWriteReq(dcWriteReq), .dcWriteAddr(dcWriteAddr), .dcWriteData(dcWriteData), .dcWriteAck(dcWriteAck),
      .memAccessRE(memAccessRE), .memAccessWE(memAccessWE), .memAccessAddr(memAccessAddr),
      .memAccessWriteData(memAccessWriteData),
      .memAccessReadBusy(memAccessReadBusy), .memAccessWriteBusy(memAccessWriteBusy),
      .nextMemReadSerial(nextMemReadSerial),
      .memReadDataReady(memReadDataReady), .memReadSerial(memReadSerial), .memReadData(memReadData),
      .icRespValid(icRespValid), .dcRespValid(dcRespValid), .respData(respData),
      .unknownSerialError(unknownSerialError)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: requester 0=IC 1=DCR 2=DCW; owner map serial -> 0 (IC) / 1 (DC).
   int          m_ptr;
   int          m_cnt;
   int          m_owner [int];
   bit          m_err;
   int          m_starve [3];
   bit          m_ack [3];
   bit          e_re, e_we;
   logic [31:0] e_addr;
   logic [63:0] e_wd;
   logic [2:0]  obs_ack;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0;
      m_cnt = 0;
      m_owner.delete();
      m_err = 1'b0;
      for (int i = 0; i < 3; i++) begin
         m_starve[i] = 0;
         m_ack[i]    = 1'b0;
      end
      e_re = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
   endtask

   function automatic int free_serial();
      for (int s = 0; s < 8; s++) begin
         if (!m_owner.exists(s)) return s;
      end
      return 0;
   endfunction

   // Check one cycle against the model, then advance the model past the next rising edge.
   task automatic step(input string tag);
      bit req [3];
      bit elig [3];
      bit rd_ok;
      bit hit;
      int win;
      int own;
      int rs;
      int ns;
      #1;
      req[0] = icReq; req[1] = dcReadReq; req[2] = dcWriteReq;
      rs = int'(memReadSerial);
      ns = int'(nextMemReadSerial);
      chk({tag, "/re"},   64'(memAccessRE),        64'(e_re));
      chk({tag, "/we"},   64'(memAccessWE),        64'(e_we));
      chk({tag, "/addr"}, 64'(memAccessAddr),      64'(e_addr));
      chk({tag, "/wd"},   memAccessWriteData,      e_wd);
      chk({tag, "/err"},  64'(unknownSerialError), 64'(m_err));
      win = -1;
      if (!rst) begin
         rd_ok   = !memAccessReadBusy && (m_cnt < MAXO);
         elig[0] = req[0] && rd_ok;
         elig[1] = req[1] && rd_ok;
         elig[2] = req[2] && !memAccessWriteBusy;
`ifdef RSD_MEM_ARB_STARVATION_GUARD_EN
         for (int i = 0; i < 3; i++) begin
            if (win < 0 && elig[i] && m_starve[i] >= SLIM) win = i;
         end
`endif
         for (int k = 0; k < 3; k++) begin
            if (win < 0 && elig[(m_ptr + k) % 3]) win = (m_ptr + k) % 3;
         end
      end
      for (int i = 0; i < 3; i++) m_ack[i] = (win == i);
      obs_ack = {dcWriteAck, dcReadAck, icAck};
      chk({tag, "/ack"}, 64'(obs_ack), 64'({m_ack[2], m_ack[1], m_ack[0]}));
      hit = !rst && memReadDataReady && m_owner.exists(rs);
      own = hit ? m_owner[rs] : -1;
      chk({tag, "/icresp"}, 64'(icRespValid), 64'(hit && own == 0));
      chk({tag, "/dcresp"}, 64'(dcRespValid), 64'(hit && own == 1));
      chk({tag, "/rdata"},  respData, hit ? memReadData : 64'd0);
      if (rst) begin
         model_reset();
      end else begin
         if (memReadDataReady && !hit) m_err = 1'b1;
         if (hit) begin
            m_owner.delete(rs);
            m_cnt--;
         end
         if (win == 0 || win == 1) begin
            if (m_owner.exists(ns)) m_err = 1'b1;
            m_owner[ns] = (win == 0) ? 0 : 1;
            m_cnt++;
         end
         e_re   = (win == 0 || win == 1);
         e_we   = (win == 2);
         e_addr = (win == 0) ? icAddr : (win == 1) ? dcReadAddr : (win == 2) ? dcWriteAddr : 32'd0;
         e_wd   = (win == 2) ? dcWriteData : 64'd0;
         if (win >= 0) m_ptr = (win + 1) % 3;
         for (int i = 0; i < 3; i++) begin
            if (m_ack[i]) m_starve[i] = 0;
            else if (req[i]) m_starve[i]++;
         end
      end
   endtask

   task automatic idle_inputs();
      icReq = 0; dcReadReq = 0; dcWriteReq = 0;
      memAccessReadBusy = 0; memAccessWriteBusy = 0;
      memReadDataReady = 0;
   endtask

   // Refresh payload of anything acked last cycle (requests stay high) and offer a free serial.
   task automatic hold_next();
      if (m_ack[0]) icAddr = $urandom;
      if (m_ack[1]) dcReadAddr = $urandom;
      if (m_ack[2]) begin dcWriteAddr = $urandom; dcWriteData = {$urandom, $urandom}; end
      nextMemReadSerial = 3'(free_serial());
   endtask

   task automatic reset_dut();
      @(negedge clk); idle_inputs(); rst = 1; step("rst");
      @(negedge clk); rst = 0; step("post_rst");
   endtask

   task automatic drain();
      int s;
      while (m_owner.num() > 0) begin
         void'(m_owner.first(s));
         @(negedge clk);
         idle_inputs();
         memReadDataReady = 1; memReadSerial = 3'(s); memReadData = {$urandom, $urandom};
         step("drain");
      end
      @(negedge clk); idle_inputs(); step("drained");
   endtask

   initial begin
      int q [$];
      rst = 1; idle_inputs();
      icAddr = '0; dcReadAddr = '0; dcWriteAddr = '0; dcWriteData = '0;
      nextMemReadSerial = '0; memReadSerial = '0; memReadData = '0;
      model_reset();

      // Reset state.
      @(negedge clk); step("reset0");
      chk("reset_re", 64'(memAccessRE), 64'd0);
      @(negedge clk); rst = 0; step("idle0");

      // All three requesting: IC, DCR, DCW, IC.
      @(negedge clk);
      icReq = 1; dcReadReq = 1; dcWriteReq = 1;
      icAddr = $urandom; dcReadAddr = $urandom; dcWriteAddr = $urandom; dcWriteData = {$urandom, $urandom};
      hold_next(); step("rr0"); chk("rr0_order", 64'(obs_ack), 64'(3'b001));
      @(negedge clk); hold_next(); step("rr1"); chk("rr1_order", 64'(obs_ack), 64'(3'b010));
      @(negedge clk); hold_next(); step("rr2"); chk("rr2_order", 64'(obs_ack), 64'(3'b100));
      @(negedge clk); hold_next(); step("rr3"); chk("rr3_order", 64'(obs_ack), 64'(3'b001));
      @(negedge clk); idle_inputs(); step("rr_port");
      drain();

      // Fill the table with 8 DC reads, then stall reads while a write still goes through.
      reset_dut();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); dcReadReq = 1; dcReadAddr = $urandom; nextMemReadSerial = 3'(i);
         step("fill"); chk("fill_ack", 64'(obs_ack), 64'(3'b010));
      end
      @(negedge clk); dcWriteReq = 1; dcWriteAddr = $urandom; dcWriteData = {$urandom, $urandom};
      step("full"); chk("full_only_write", 64'(obs_ack), 64'(3'b100));
      @(negedge clk); dcWriteReq = 0; memReadDataReady = 1; memReadSerial = 3'd3; memReadData = {$urandom, $urandom};
      step("ret3"); chk("ret3_dcresp", 64'(dcRespValid), 64'd1); chk("ret3_pre_count_block", 64'(obs_ack), 64'd0);
      @(negedge clk); memReadDataReady = 0; nextMemReadSerial = 3'd3;
      step("reaccept"); chk("reaccept_ack", 64'(obs_ack), 64'(3'b010));
      @(negedge clk); idle_inputs(); step("fill_end");
      drain();

      // Out-of-order returns for mixed owners.
      reset_dut();
      @(negedge clk); icReq = 1; icAddr = $urandom; nextMemReadSerial = 3'd1; step("ooo_ic");
      @(negedge clk); icReq = 0; dcReadReq = 1; dcReadAddr = $urandom; nextMemReadSerial = 3'd5; step("ooo_dc");
      @(negedge clk); dcReadReq = 0; memReadDataReady = 1; memReadSerial = 3'd5; memReadData = 64'hA5A5_0000_1234_5555;
      step("ooo_r5");
      chk("ooo_r5_dc", 64'(dcRespValid), 64'd1);
      chk("ooo_r5_data", respData, 64'hA5A5_0000_1234_5555);
      @(negedge clk); memReadSerial = 3'd1; memReadData = 64'h0F0F_1111_2222_3333;
      step("ooo_r1");
      chk("ooo_r1_ic", 64'(icRespValid), 64'd1);
      chk("ooo_r1_data", respData, 64'h0F0F_1111_2222_3333);

      // Return on a serial that was never issued.
      @(negedge clk); memReadSerial = 3'd6; memReadData = {$urandom, $urandom};
      step("unk"); chk("unk_noresp", 64'({icRespValid, dcRespValid}), 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); idle_inputs(); step("unk_hold");
      end
      chk("unk_sticky", 64'(unknownSerialError), 64'd1);
      reset_dut();
      chk("unk_cleared", 64'(unknownSerialError), 64'd0);

      // Read port busy: only the write is served; IC wins once busy drops.
      @(negedge clk);
      icReq = 1; dcReadReq = 1; dcWriteReq = 1; memAccessReadBusy = 1;
      icAddr = $urandom; dcReadAddr = $urandom; dcWriteAddr = $urandom; dcWriteData = {$urandom, $urandom};
      for (int i = 0; i < 20; i++) begin
         if (i > 0) @(negedge clk);
         hold_next(); step("busy"); chk("busy_write_only", 64'(obs_ack), 64'(3'b100));
      end
      @(negedge clk); memAccessReadBusy = 0; hold_next();
      step("busy_drop"); chk("busy_drop_ic", 64'(obs_ack), 64'(3'b001));
      @(negedge clk); idle_inputs(); step("busy_end");
      drain();

      // Reset with 3 reads outstanding.
      reset_dut();
      @(negedge clk); icReq = 1; dcReadReq = 1; icAddr = $urandom; dcReadAddr = $urandom;
      hold_next(); step("pre_rst");
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); hold_next(); step("pre_rst");
      end
      @(negedge clk); idle_inputs(); rst = 1; step("mid_rst");
      @(negedge clk); rst = 0; step("after_rst");
      chk("after_rst_re", 64'(memAccessRE), 64'd0);
      @(negedge clk); memReadDataReady = 1; memReadSerial = 3'd1; step("old_serial");
      chk("old_serial_noresp", 64'({icRespValid, dcRespValid}), 64'd0);
      @(negedge clk); idle_inputs(); step("old_serial_err");
      chk("old_serial_err", 64'(unknownSerialError), 64'd1);
      reset_dut();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); dcReadReq = 1; dcReadAddr = $urandom; nextMemReadSerial = 3'(i);
         step("count_zero"); chk("count_zero_ack", 64'(obs_ack), 64'(3'b010));
      end
      reset_dut();

      // Randomized traffic.
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (!icReq || m_ack[0]) begin icReq = ($urandom % 3) != 0; icAddr = $urandom; end
         if (!dcReadReq || m_ack[1]) begin dcReadReq = ($urandom % 3) != 0; dcReadAddr = $urandom; end
         if (!dcWriteReq || m_ack[2]) begin
            dcWriteReq = ($urandom % 3) != 0; dcWriteAddr = $urandom; dcWriteData = {$urandom, $urandom};
         end
         memAccessReadBusy  = ($urandom % 4) == 0;
         memAccessWriteBusy = ($urandom % 4) == 0;
         nextMemReadSerial  = 3'(free_serial());
         memReadDataReady   = 0;
         memReadData        = {$urandom, $urandom};
         if (m_owner.num() > 0 && ($urandom % 3) == 0) begin
            q.delete();
            foreach (m_owner[k]) q.push_back(k);
            memReadDataReady = 1;
            memReadSerial    = 3'(q[$urandom_range(0, q.size() - 1)]);
         end else if (($urandom % 40) == 0) begin
            memReadDataReady = 1;
            memReadSerial    = 3'($urandom_range(0, 7));
         end
         step("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/memory_request_arbiter.md
MEMORY_REQUEST_ARBITER -- requirements
Module: memory_request_arbiter

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 8: maximum in-flight reads; range 1..2^MEM_ACCESS_SERIAL_BIT_SIZE.
REQ-002 Parameter STARVE_LIMIT, default 16: consecutive unacked cycles before starvation override.
REQ-003 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 icReq / icAddr / icAck  in / in / out  1 / PHY_ADDR_WIDTH / 1  ICache fill read request.
REQ-007 dcReadReq / dcReadAddr / dcReadAck  in / in / out  1 / PHY_ADDR_WIDTH / 1  DCache fill read request.
REQ-008 dcWriteReq / dcWriteAddr / dcWriteData / dcWriteAck  in / in / in / out  1 / PHY_ADDR_WIDTH / MEMORY_ENTRY_BIT_NUM / 1  DCache writeback.
REQ-009 memAccessRE, memAccessWE, memAccessAddr, memAccessWriteData  out  1, 1, PHY_ADDR_WIDTH, MEMORY_ENTRY_BIT_NUM  registered memory port.
REQ-010 memAccessReadBusy, memAccessWriteBusy  in  1 each  memory port back-pressure.
REQ-011 nextMemReadSerial  in  MEM_ACCESS_SERIAL_BIT_SIZE  serial the memory assigns to the next accepted read.
REQ-012 memReadDataReady, memReadSerial, memReadData  in  1, MEM_ACCESS_SERIAL_BIT_SIZE, MEMORY_ENTRY_BIT_NUM  read return.
REQ-013 icRespValid, dcRespValid, respData  out  1, 1, MEMORY_ENTRY_BIT_NUM  routed read return.
REQ-014 unknownSerialError  out  1  sticky error flag.

Function
REQ-015 Requesters SHALL hold req and payload stable until ack; ack is a combinational single-cycle pulse in the acceptance cycle T.
REQ-016 At most one request SHALL be accepted per cycle; the accepted request appears on memAccessRE/WE, Addr and WriteData in cycle T+1 for exactly one cycle.
REQ-017 A read is eligible only if memAccessReadBusy=0 and outstanding count < MAX_OUTSTANDING at T; a write is eligible only if memAccessWriteBusy=0 at T.
REQ-018 Eligible requesters SHALL be served round-robin in order IC(0), DCR(1), DCW(2); the pointer moves to winner+1 (mod 3) after each grant and holds otherwise.
REQ-019 On read acceptance, the owner table entry indexed by nextMemReadSerial SHALL record valid=1 plus owner (IC/DC); outstanding count +1.
REQ-020 On memReadDataReady with a valid entry at memReadSerial: same cycle, assert icRespValid or dcRespValid per owner; respData=memReadData; entry cleared and count -1 at next edge.
REQ-021 On memReadDataReady with an invalid entry: no RespValid; unknownSerialError set and held until reset.
REQ-022 Simultaneous read accept and read return in one cycle: count SHALL stay unchanged; both table updates apply; with count==MAX_OUTSTANDING, accept blocking uses the pre-return count.
REQ-023 Acceptance to a serial whose entry is already valid SHALL overwrite it and set unknownSerialError.
REQ-024 respData SHALL be zero when neither RespValid is asserted.

Reset
REQ-025 On rst: all outputs 0, owner table cleared, count 0, pointer 0, starvation counters 0, error flag 0.
REQ-026 rst mid-transfer SHALL discard all in-flight state; returns arriving after reset follow REQ-021.

Configuration
REQ-027 Macro RSD_MEM_ARB_STARVATION_GUARD_EN defined: per-requester counter increments each cycle req=1 and ack=0; an eligible requester whose counter has reached STARVE_LIMIT wins over round-robin (lowest index among several); counter clears on ack.
REQ-028 Macro undefined: pure round-robin; no counters synthesized.

Structure
REQ-029 Shared package holds the MemArbRequester enum (IC, DCR, DCW), the owner-entry struct (valid, owner), and MEM_ARB_MAX_OUTSTANDING and MEM_ARB_STARVE_LIMIT defaults.
REQ-030 Sub-module mem_arb_round_robin (3-way rotating-priority picker with override input) SHALL be instantiated once.

Verification
REQ-031 icReq, dcReadReq, dcWriteReq all high from reset, no busy -> acks in order IC, DCR, DCW, IC over 4 cycles; each appears on the memory port in the following cycle.
REQ-032 8 DC reads accepted with serials 0..7 and no returns -> 9th read stalls and dcWriteReq is still acked; a return on serial 3 -> dcRespValid, next read accepted one cycle later.
REQ-033 Returns out of order (serials 5, 1) for mixed owners -> each returned to the correct owner with matching data.
REQ-034 memReadDataReady with serial 6 never issued -> no RespValid; unknownSerialError=1 until rst.
REQ-035 memAccessReadBusy=1 for 10 cycles with all three requesting -> only DCW acked meanwhile; with the guard enabled and readBusy held for 20 cycles, IC wins in the first cycle busy drops.
REQ-036 rst asserted with 3 reads outstanding -> count 0, all outputs 0 next cycle; a later return on an old serial raises unknownSerialError.
